// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the decode interlock / bypass-select scoreboard.
package hazard_scoreboard_pkg;

    localparam int DEF_NREG    = 32;
    localparam int DEF_MAX_LAT = 4;
    localparam int DEF_AW      = $clog2(DEF_NREG);
    localparam int DEF_LW      = $clog2(DEF_MAX_LAT + 1);

    typedef enum logic {
        FWD_RF = 1'b0,
        FWD_WB = 1'b1
    } FwdSel;

    typedef struct packed {
        logic                valid;
        logic                wen;
        logic [DEF_AW-1:0]   rd;
        logic [DEF_LW-1:0]   lat;
    } IssueReq;

endpackage

// File: rtl/hazard_scoreboard_wb_slot_shifter.sv
// Writeback slot queue: slot k holds the write that retires k edges from now.
module wb_slot_shifter #(
    parameter int MAX_LAT = 4,
    parameter int AW      = 5,
    parameter int LW      = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hold,
    input  logic               flush,
    input  logic               ins_valid,
    input  logic [LW-1:0]      ins_lat,
    input  logic [AW-1:0]      ins_addr,
    output logic [MAX_LAT-1:1] slot_busy,
    output logic               wb_valid,
    output logic [AW-1:0]      wb_addr,
    output logic [LW:0]        pending
);

    logic [MAX_LAT-1:0] v_vec;
    logic [AW-1:0]      a_vec [MAX_LAT];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LAT; gi++) begin : g_slot
            logic          v_reg, v_next, v_up;
            logic [AW-1:0] a_reg, a_next, a_up;

            if (gi == MAX_LAT - 1) begin : g_top
                assign v_up = 1'b0;
                assign a_up = '0;
            end else begin : g_mid
                assign v_up = v_vec[gi+1];
                assign a_up = a_vec[gi+1];
            end

            // Empty slots always carry address 0 so wb_addr reads 0 when idle.
            always_comb begin
                v_next = v_reg;
                a_next = a_reg;
                if (flush) begin
                    v_next = 1'b0;
                    a_next = '0;
                end else if (!hold) begin
                    if (ins_valid && ins_lat == LW'(gi + 1)) begin
                        v_next = 1'b1;
                        a_next = ins_addr;
                    end else begin
                        v_next = v_up;
                        a_next = a_up;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v_reg <= 1'b0;
                    a_reg <= '0;
                end else begin
                    v_reg <= v_next;
                    a_reg <= a_next;
                end
            end

            assign v_vec[gi] = v_reg;
            assign a_vec[gi] = a_reg;
        end
    endgenerate

    assign slot_busy = v_vec[MAX_LAT-1:1];
    assign wb_valid  = v_vec[0];
    assign wb_addr   = a_vec[0];

    always_comb begin
        pending = '0;
        for (int k = 0; k < MAX_LAT; k++) begin
            pending = pending + (LW+1)'(v_vec[k]);
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode interlock: per-register pending-latency counters, RAW/WAW/port hazards
// and per-read-port bypass select.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int  NREG    = 32,
    parameter int  NREAD   = 2,
    parameter int  MAX_LAT = 4,
    localparam int AW      = $clog2(NREG),
    localparam int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                issue_valid,
    input  logic                issue_wen,
    input  logic [AW-1:0]       issue_rd,
    input  logic [LW-1:0]       issue_lat,
    input  logic [NREAD*AW-1:0] issue_rs_addr,
    input  logic [NREAD-1:0]    issue_rs_used,
    input  logic                hold,
    input  logic                flush,
    output logic                stall,
    output logic [NREAD-1:0]    fwd_sel,
    output logic                wb_valid,
    output logic [AW-1:0]       wb_addr,
    output logic [LW:0]         pending,
    output logic                lat_err
);

    logic [LW-1:0]      cnt_vec [NREG];
    logic [NREAD-1:0]   raw_hit;
    logic [MAX_LAT-1:1] conflict_hit;
    logic [MAX_LAT-1:1] slot_busy;
    logic               lat_ok, rd_tracked, waw, conflict, accept_wr;

    assign lat_ok     = (issue_lat != '0) && (issue_lat <= LW'(MAX_LAT));
    assign lat_err    = issue_valid && !lat_ok;
    assign rd_tracked = issue_wen && (issue_rd != '0);

    // Counters live in the post-edge frame: a new write of latency L retires
    // L+1 edges from now, so an older write with cnt <= L retires first.
    assign waw      = rd_tracked && (cnt_vec[issue_rd] > issue_lat);
    assign conflict = rd_tracked && (|conflict_hit);
    assign stall    = issue_valid && ((|raw_hit) || waw || conflict || !lat_ok);
    assign accept_wr = issue_valid && !stall && !hold && !flush && rd_tracked;

    genvar gi;
    generate
        for (gi = 0; gi < NREAD; gi++) begin : g_port
            logic [AW-1:0] rs;
            assign rs          = issue_rs_addr[gi*AW +: AW];
            assign raw_hit[gi] = issue_rs_used[gi] && (rs != '0) && (cnt_vec[rs] >= LW'(2));
            assign fwd_sel[gi] = ((rs != '0) && (cnt_vec[rs] == LW'(1))) ? FWD_WB : FWD_RF;
        end

        // The insert lands after the shift, so it collides with whatever
        // currently sits one slot above its latency.
        for (gi = 1; gi < MAX_LAT; gi++) begin : g_conf
            assign conflict_hit[gi] = (issue_lat == LW'(gi)) && slot_busy[gi];
        end

        for (gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign cnt_vec[gi] = '0;
            end else begin : g_track
                logic [LW-1:0] cnt_reg;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_reg <= '0;
                    end else if (flush) begin
                        cnt_reg <= '0;
                    end else if (!hold) begin
                        if (accept_wr && issue_rd == AW'(gi)) begin
                            cnt_reg <= issue_lat;
                        end else if (cnt_reg != '0) begin
                            cnt_reg <= cnt_reg - LW'(1);
                        end
                    end
                end
                assign cnt_vec[gi] = cnt_reg;
            end
        end
    endgenerate

    wb_slot_shifter #(
        .MAX_LAT (MAX_LAT),
        .AW      (AW),
        .LW      (LW)
    ) u_slots (
        .clk       (clk),
        .rst_n     (rst_n),
        .hold      (hold),
        .flush     (flush),
        .ins_valid (accept_wr),
        .ins_lat   (issue_lat),
        .ins_addr  (issue_rd),
        .slot_busy (slot_busy),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .pending   (pending)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
    import hazard_scoreboard_pkg::*;

    localparam int NREG    = 32;
    localparam int NREAD   = 2;
    localparam int MAX_LAT = 4;
    localparam int AW      = 5;
    localparam int LW      = 3;

    logic                clk;
    logic                rst_n;
    logic                issue_valid;
    logic                issue_wen;
    logic [AW-1:0]       issue_rd;
    logic [LW-1:0]       issue_lat;
    logic [NREAD*AW-1:0] issue_rs_addr;
    logic [NREAD-1:0]    issue_rs_used;
    logic                hold;
    logic                flush;
    logic                stall;
    logic [NREAD-1:0]    fwd_sel;
    logic                wb_valid;
    logic [AW-1:0]       wb_addr;
    logic [LW:0]         pending;
    logic                lat_err;

    int vectors     = 0;
    int miscompares = 0;

    hazard_scoreboard #(
        .NREG    (NREG),
        .NREAD   (NREAD),
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid   (issue_valid),
        .issue_wen     (issue_wen),
        .issue_rd      (issue_rd),
        .issue_lat     (issue_lat),
        .issue_rs_addr (issue_rs_addr),
        .issue_rs_used (issue_rs_used),
        .hold          (hold),
        .flush         (flush),
        .stall         (stall),
        .fwd_sel       (fwd_sel),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .pending       (pending),
        .lat_err       (lat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic present(input logic v, input logic wen, input logic [AW-1:0] rd,
                           input logic [LW-1:0] lat, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs0, input logic [1:0] used);
        IssueReq req;
        req           = '{valid: v, wen: wen, rd: rd, lat: lat};
        issue_valid   = req.valid;
        issue_wen     = req.wen;
        issue_rd      = req.rd;
        issue_lat     = req.lat;
        issue_rs_addr = {rs1, rs0};
        issue_rs_used = used;
        #1;
    endtask

    task automatic idle();
        present(1'b0, 1'b0, '0, '0, '0, '0, 2'b00);
    endtask

    initial begin
        rst_n = 1'b0;
        hold  = 1'b0;
        flush = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        check("rst stall", stall, 0);
        check("rst fwd_sel", fwd_sel, 0);
        check("rst wb_valid", wb_valid, 0);
        check("rst wb_addr", wb_addr, 0);
        check("rst pending", pending, 0);
        check("rst lat_err", lat_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // RAW: r5 latency 3, consumer stalls two cycles then forwards
        present(1, 1, 5, 3, 0, 0, 2'b00);
        check("A issue stall", stall, 0);
        @(negedge clk);
        present(1, 0, 0, 1, 0, 5, 2'b01);
        check("A c1 stall", stall, 1);
        check("A c1 fwd_sel", fwd_sel, 0);
        check("A c1 pending", pending, 1);
        check("A c1 wb_valid", wb_valid, 0);
        @(negedge clk);
        check("A c2 stall", stall, 1);
        check("A c2 wb_valid", wb_valid, 0);
        @(negedge clk);
        check("A c3 stall", stall, 0);
        check("A c3 fwd_sel", fwd_sel, 2'b01);
        check("A c3 wb_valid", wb_valid, 1);
        check("A c3 wb_addr", wb_addr, 5);
        @(negedge clk);
        idle();
        check("A drained pending", pending, 0);
        check("A drained wb_valid", wb_valid, 0);

        // Write-port conflict: r7 L4 then r8 L3
        present(1, 1, 7, 4, 0, 0, 2'b00);
        check("B r7 stall", stall, 0);
        @(negedge clk);
        present(1, 1, 8, 3, 0, 0, 2'b00);
        check("B r8 conflict stall", stall, 1);
        @(negedge clk);
        check("B r8 retry stall", stall, 0);
        @(negedge clk);
        idle();
        check("B pending", pending, 2);
        check("B wb_valid early", wb_valid, 0);
        @(negedge clk);
        check("B wb7 valid", wb_valid, 1);
        check("B wb7 addr", wb_addr, 7);
        @(negedge clk);
        check("B wb8 valid", wb_valid, 1);
        check("B wb8 addr", wb_addr, 8);
        @(negedge clk);
        check("B drained pending", pending, 0);

        // WAW: r9 L4 then r9 L1 waits until cnt[9] = 1
        present(1, 1, 9, 4, 0, 0, 2'b00);
        @(negedge clk);
        present(1, 1, 9, 1, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("C waw stall %0d", i), stall, 1);
            @(negedge clk);
        end
        check("C accept stall", stall, 0);
        check("C old wb_addr", wb_addr, 9);
        @(negedge clk);
        idle();
        check("C new wb_valid", wb_valid, 1);
        check("C new wb_addr", wb_addr, 9);
        check("C new pending", pending, 1);
        @(negedge clk);
        check("C drained pending", pending, 0);

        // Flush under hold with writes at 1/2/3 remaining
        present(1, 1, 10, 3, 0, 0, 2'b00);
        @(negedge clk);
        present(1, 1, 11, 3, 0, 0, 2'b00);
        check("D r11 stall", stall, 0);
        @(negedge clk);
        present(1, 1, 12, 3, 0, 0, 2'b00);
        check("D r12 stall", stall, 0);
        @(negedge clk);
        idle();
        check("D pending 3", pending, 3);
        check("D wb_addr 10", wb_addr, 10);
        hold  = 1'b1;
        flush = 1'b1;
        present(1, 1, 13, 2, 10, 11, 2'b01);
        check("D flush raw stall", stall, 1);
        check("D flush fwd_sel", fwd_sel, 2'b10);
        @(negedge clk);
        hold  = 1'b0;
        flush = 1'b0;
        present(1, 0, 0, 1, 13, 11, 2'b11);
        check("D post pending", pending, 0);
        check("D post wb_valid", wb_valid, 0);
        check("D post stall", stall, 0);
        check("D post fwd_sel", fwd_sel, 0);
        @(negedge clk);
        idle();

        // Hold for 5 cycles with r14 at cnt = 2
        present(1, 1, 14, 3, 0, 0, 2'b00);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("E pre pending", pending, 1);
        check("E pre wb_valid", wb_valid, 0);
        hold = 1'b1;
        present(1, 0, 0, 1, 0, 14, 2'b01);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("E hold stall %0d", i), stall, 1);
            check($sformatf("E hold wb_valid %0d", i), wb_valid, 0);
            check($sformatf("E hold pending %0d", i), pending, 1);
            @(negedge clk);
        end
        hold = 1'b0;
        #1;
        check("E resume stall", stall, 1);
        @(negedge clk);
        check("E fwd stall", stall, 0);
        check("E fwd_sel", fwd_sel, 2'b01);
        check("E wb_valid", wb_valid, 1);
        check("E wb_addr", wb_addr, 14);
        @(negedge clk);
        idle();

        // Illegal latencies and untracked r0
        present(1, 1, 3, 0, 0, 0, 2'b00);
        check("F lat0 lat_err", lat_err, 1);
        check("F lat0 stall", stall, 1);
        @(negedge clk);
        idle();
        check("F lat0 pending", pending, 0);
        present(1, 1, 3, 5, 0, 0, 2'b00);
        check("F lat5 lat_err", lat_err, 1);
        check("F lat5 stall", stall, 1);
        @(negedge clk);
        idle();
        check("F lat5 pending", pending, 0);
        present(0, 1, 3, 0, 0, 0, 2'b00);
        check("F novalid lat_err", lat_err, 0);
        check("F novalid stall", stall, 0);
        present(1, 1, 0, 2, 0, 0, 2'b00);
        check("F r0 stall", stall, 0);
        @(negedge clk);
        idle();
        check("F r0 pending", pending, 0);
        @(negedge clk);
        check("F r0 wb_valid", wb_valid, 0);

        // Asynchronous reset mid-operation
        present(1, 1, 6, 4, 0, 0, 2'b00);
        @(negedge clk);
        idle();
        check("G pre pending", pending, 1);
        rst_n = 1'b0;
        #1;
        check("G async pending", pending, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("G post pending", pending, 0);
        check("G post wb_valid", wb_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
